// File: rtl/popcount_pipe.sv
// Pipelined population counter: registered adder tree with an aligned tag pipeline,
// followed by a registered threshold compare and a saturating running accumulator.
module popcount_pipe #(
    parameter int N_IN = 16,
    parameter int ACC_W = 16,
    localparam int CNT_W = $clog2(N_IN + 1),
    localparam int LEVELS = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_data,
    input  logic [CNT_W-1:0] in_thresh,
    input  logic             in_acc_en,
    input  logic             in_acc_clr,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    output logic             out_hit,
    output logic [ACC_W-1:0] acc_count,
    output logic             acc_sat
);

    localparam int PAD_W = 1 << LEVELS;

    logic [PAD_W-1:0] data_pad;
    assign data_pad = PAD_W'(in_data);

    // Level k holds PAD_W>>k partial sums, each k+1 bits wide; level 0 is the input register.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int NODES = PAD_W >> k;
        logic [k:0] sum [NODES];

        if (k == 0) begin : g_leaf
            always_ff @(posedge clk) begin
                for (int i = 0; i < NODES; i++) begin
                    sum[i] <= data_pad[i];
                end
            end
        end else begin : g_add
            always_ff @(posedge clk) begin
                for (int i = 0; i < NODES; i++) begin
                    sum[i] <= {1'b0, g_lvl[k-1].sum[2*i]} + {1'b0, g_lvl[k-1].sum[2*i+1]};
                end
            end
        end
    end

    logic             tag_valid  [LEVELS+1];
    logic [CNT_W-1:0] tag_thresh [LEVELS+1];
    logic             tag_en     [LEVELS+1];
    logic             tag_clr    [LEVELS+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= LEVELS; i++) begin
                tag_valid[i] <= 1'b0;
            end
        end else begin
            tag_valid[0] <= in_valid;
            for (int i = 1; i <= LEVELS; i++) begin
                tag_valid[i] <= tag_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_thresh[0] <= in_thresh;
        tag_en[0]     <= in_acc_en;
        tag_clr[0]    <= in_acc_clr;
        for (int i = 1; i <= LEVELS; i++) begin
            tag_thresh[i] <= tag_thresh[i-1];
            tag_en[i]     <= tag_en[i-1];
            tag_clr[i]    <= tag_clr[i-1];
        end
    end

    logic [LEVELS:0] final_sum;
    logic [ACC_W:0]  acc_sum;

    // The final sum never exceeds N_IN, so dropping its top bit for out_count loses nothing.
    assign final_sum = g_lvl[LEVELS].sum[0];
    assign acc_sum   = {1'b0, acc_count} + (ACC_W+1)'(final_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_hit   <= 1'b0;
            acc_count <= '0;
            acc_sat   <= 1'b0;
        end else begin
            out_valid <= tag_valid[LEVELS];
            if (tag_valid[LEVELS]) begin
                out_count <= final_sum[CNT_W-1:0];
                out_hit   <= final_sum >= (LEVELS+1)'(tag_thresh[LEVELS]);
                if (tag_clr[LEVELS]) begin
                    acc_count <= ACC_W'(final_sum);
                    acc_sat   <= 1'b0;
                end else if (tag_en[LEVELS]) begin
                    if (acc_sum[ACC_W]) begin
                        acc_count <= {ACC_W{1'b1}};
                        acc_sat   <= 1'b1;
                    end else begin
                        acc_count <= acc_sum[ACC_W-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_popcount_pipe.sv
// Directed bench for popcount_pipe at N_IN=16/ACC_W=6, N_IN=13 and N_IN=2,
// with a scoreboard queue per instance compared every cycle.
module tb_popcount_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    logic        v0 = 0, e0 = 0, c0 = 0;
    logic [15:0] d0 = '0;
    logic [4:0]  t0 = '0;
    logic        ov0, oh0, sat0;
    logic [4:0]  oc0;
    logic [5:0]  acc0;

    logic        v1 = 0, e1 = 0, c1 = 0;
    logic [12:0] d1 = '0;
    logic [3:0]  t1 = '0;
    logic        ov1, oh1, sat1;
    logic [3:0]  oc1;
    logic [15:0] acc1;

    logic        v2 = 0, e2 = 0, c2 = 0;
    logic [1:0]  d2 = '0;
    logic [1:0]  t2 = '0;
    logic        ov2, oh2, sat2;
    logic [1:0]  oc2;
    logic [15:0] acc2;

    popcount_pipe #(.N_IN(16), .ACC_W(6)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0), .in_thresh(t0),
        .in_acc_en(e0), .in_acc_clr(c0), .out_valid(ov0), .out_count(oc0),
        .out_hit(oh0), .acc_count(acc0), .acc_sat(sat0));

    popcount_pipe #(.N_IN(13), .ACC_W(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_thresh(t1),
        .in_acc_en(e1), .in_acc_clr(c1), .out_valid(ov1), .out_count(oc1),
        .out_hit(oh1), .acc_count(acc1), .acc_sat(sat1));

    popcount_pipe #(.N_IN(2), .ACC_W(16)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .in_thresh(t2),
        .in_acc_en(e2), .in_acc_clr(c2), .out_valid(ov2), .out_count(oc2),
        .out_hit(oh2), .acc_count(acc2), .acc_sat(sat2));

    typedef struct {
        int          due;
        logic [31:0] cnt;
        logic [31:0] hit;
        logic [31:0] acc;
        logic [31:0] sat;
    } exp_t;

    exp_t q [3][$];
    exp_t last [3];
    int   acc_m [3];
    int   sat_m [3];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic int lvl(int d);
        return (d == 2) ? 1 : 4;
    endfunction

    function automatic int amax(int d);
        return (d == 0) ? 63 : 65535;
    endfunction

    task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc %0d: got %0d expected %0d", tag, d, cyc, obs, exp);
        end
    endtask

    task automatic model_in(int d, logic v, logic [15:0] data, int thr, logic en, logic clr);
        exp_t e;
        int   c;
        if (!v) return;
        c = $countones(data);
        if (clr) begin
            acc_m[d] = c;
            sat_m[d] = 0;
        end else if (en) begin
            if (acc_m[d] + c > amax(d)) begin
                acc_m[d] = amax(d);
                sat_m[d] = 1;
            end else begin
                acc_m[d] = acc_m[d] + c;
            end
        end
        e.due = cyc + lvl(d) + 2;
        e.cnt = c;
        e.hit = (c >= thr) ? 1 : 0;
        e.acc = acc_m[d];
        e.sat = sat_m[d];
        q[d].push_back(e);
    endtask

    task automatic step();
        logic        ev;
        logic [31:0] ov, oc, oh, oa, os;
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                q[d].delete();
                acc_m[d] = 0;
                sat_m[d] = 0;
                last[d] = '{0, 0, 0, 0, 0};
            end
        end else begin
            model_in(0, v0, d0, int'(t0), e0, c0);
            model_in(1, v1, 16'(d1), int'(t1), e1, c1);
            model_in(2, v2, 16'(d2), int'(t2), e2, c2);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            ev = (q[d].size() > 0) && (q[d][0].due == cyc);
            if (ev) last[d] = q[d].pop_front();
            case (d)
                0: begin ov = 32'(ov0); oc = 32'(oc0); oh = 32'(oh0); oa = 32'(acc0); os = 32'(sat0); end
                1: begin ov = 32'(ov1); oc = 32'(oc1); oh = 32'(oh1); oa = 32'(acc1); os = 32'(sat1); end
                default: begin ov = 32'(ov2); oc = 32'(oc2); oh = 32'(oh2); oa = 32'(acc2); os = 32'(sat2); end
            endcase
            chk("out_valid", d, ov, 32'(ev));
            chk("out_count", d, oc, last[d].cnt);
            chk("out_hit",   d, oh, last[d].hit);
            chk("acc_count", d, oa, last[d].acc);
            chk("acc_sat",   d, os, last[d].sat);
        end
        v0 = 0; v1 = 0; v2 = 0; rst = 0;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic b0(logic [15:0] data, int thr, logic en, logic clr);
        v0 = 1; d0 = data; t0 = 5'(thr); e0 = en; c0 = clr;
    endtask

    task automatic b1(logic [12:0] data, int thr, logic en, logic clr);
        v1 = 1; d1 = data; t1 = 4'(thr); e1 = en; c1 = clr;
    endtask

    task automatic b2(logic [1:0] data, int thr, logic en, logic clr);
        v2 = 1; d2 = data; t2 = 2'(thr); e2 = en; c2 = clr;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            acc_m[d] = 0;
            sat_m[d] = 0;
            last[d] = '{0, 0, 0, 0, 0};
        end

        rst = 1; step();
        rst = 1; step();
        idle(2);

        // Single full word, count at the top of the range.
        b0(16'hFFFF, 16, 0, 0); step();
        idle(7);

        // Back-to-back words with threshold 8.
        b0(16'h0000, 8, 0, 0); step();
        b0(16'h8001, 8, 0, 0); step();
        b0(16'h0F0F, 8, 0, 0); step();
        b0(16'hFFFE, 8, 0, 0); step();
        idle(7);

        // 6-bit accumulator saturation and clear.
        b0(16'hFFFF, 0, 0, 1); step();
        b0(16'hFFFF, 0, 1, 0); step();
        b0(16'hFFFF, 0, 1, 0); step();
        b0(16'hFFFF, 0, 1, 0); step();
        b0(16'hFFFF, 0, 1, 0); step();
        b0(16'h0003, 0, 0, 1); step();
        idle(7);

        // Bubbles in the valid stream.
        b0(16'h00FF, 4, 1, 0); step();
        step();
        step();
        b0(16'h0F00, 5, 1, 0); step();
        idle(7);

        // Reset while three beats are in flight; the third coincides with reset.
        b0(16'h1234, 1, 1, 0); step();
        b0(16'h5678, 1, 1, 0); step();
        b0(16'h9ABC, 1, 1, 0); rst = 1; step();
        idle(8);
        b0(16'hF0F0, 9, 1, 0); step();
        idle(7);

        // Non-power-of-two and minimum widths.
        b1(13'h1FFF, 13, 0, 1); b2(2'b11, 2, 1, 0); step();
        b1(13'h1000, 0, 1, 0);  b2(2'b01, 2, 1, 0); step();
        idle(7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
